// File: rtl/seg_to_bcd_rx.sv
// 7-segment code receiver: decodes a stream of segment codes back to BCD digits,
// packs NUM_DIGITS of them into one frame and offers it over valid/ready.
module seg_to_bcd_rx #(
  parameter int NUM_DIGITS     = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [6:0]              seg_in,
  input  logic                    seg_valid,
  output logic                    seg_ready,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    bcd_valid,
  input  logic                    bcd_ready,
  output logic                    err,
  output logic [2:0]              digit_cnt
);

  localparam int         W    = 4 * NUM_DIGITS;
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t     state;
  logic [6:0] code;
  logic [3:0] nibble;
  logic       take;

  // Normalise to the active-low form so one decode table serves both polarities.
  assign code = SEG_ACTIVE_LOW ? seg_in : ~seg_in;
  assign take = seg_valid && seg_ready;

  always_comb begin
    nibble = 4'hF;
    case (code)
      7'b1000000: nibble = 4'd0;
      7'b1111001: nibble = 4'd1;
      7'b0100100: nibble = 4'd2;
      7'b0110000: nibble = 4'd3;
      7'b0011001: nibble = 4'd4;
      7'b0010010: nibble = 4'd5;
      7'b0000010: nibble = 4'd6;
      7'b1111000: nibble = 4'd7;
      7'b0000000: nibble = 4'd8;
      7'b0011000: nibble = 4'd9;
      default:    nibble = 4'hF;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= COLLECT;
      seg_ready <= 1'b0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      err       <= 1'b0;
      digit_cnt <= 3'd0;
    end else begin
      case (state)
        COLLECT: begin
          if (clr) begin
            digit_cnt <= 3'd0;
            err       <= 1'b0;
            bcd_out   <= '0;
            seg_ready <= 1'b1;
          end else if (take) begin
            bcd_out <= {bcd_out[W-5:0], nibble};
            err     <= err | (nibble == 4'hF);
            if (digit_cnt == LAST) begin
              state     <= HOLD;
              digit_cnt <= 3'd0;
              seg_ready <= 1'b0;
              bcd_valid <= 1'b1;
            end else begin
              digit_cnt <= digit_cnt + 3'd1;
              seg_ready <= 1'b1;
            end
          end else begin
            seg_ready <= 1'b1;
          end
        end
        HOLD: begin
          // A dropped frame and a delivered frame both leave the next one clean.
          if (clr || bcd_ready) begin
            state     <= COLLECT;
            bcd_valid <= 1'b0;
            err       <= 1'b0;
            seg_ready <= 1'b1;
          end
        end
        default: begin
          state     <= COLLECT;
          seg_ready <= 1'b0;
          bcd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_to_bcd_rx.sv
// Bench for seg_to_bcd_rx: directed scenarios with literal expectations, then random
// traffic checked every cycle against a frame-level reference model.
module tb_seg_to_bcd_rx;

  localparam int N = 4;

  logic        CLOCK_50 = 1'b0;
  logic        resetn, seg_valid, clr, bcd_ready;
  logic [6:0]  seg_in;
  logic        seg_ready, bcd_valid, err;
  logic [15:0] bcd_out;
  logic [2:0]  digit_cnt;

  always #5 CLOCK_50 = ~CLOCK_50;

  seg_to_bcd_rx #(.NUM_DIGITS(N), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .seg_in(seg_in), .seg_valid(seg_valid),
    .seg_ready(seg_ready), .clr(clr), .bcd_out(bcd_out), .bcd_valid(bcd_valid),
    .bcd_ready(bcd_ready), .err(err), .digit_cnt(digit_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  function automatic int decode(logic [6:0] c);
    for (int i = 0; i < 10; i++)
      if (seg_tab[i] == c) return i;
    return 15;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks digits per frame, not registers.
  bit m_hold, m_ready, m_valid, m_err;
  int m_cnt, m_bcd, m_d;
  int cur_digits[$];
  int last_frame[$];

  function automatic int frame_val();
    int v = 0;
    foreach (last_frame[i]) v = v * 16 + last_frame[i];
    return v;
  endfunction

  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      m_hold = 0; m_ready = 0; m_valid = 0; m_err = 0; m_cnt = 0; m_bcd = 0;
      cur_digits.delete();
    end else if (!m_hold) begin
      if (clr) begin
        m_cnt = 0; m_err = 0; m_bcd = 0; m_ready = 1;
        cur_digits.delete();
      end else if (seg_valid && m_ready) begin
        m_d   = decode(seg_in);
        m_bcd = (m_bcd * 16 + m_d) % 65536;
        if (m_d == 15) m_err = 1;
        cur_digits.push_back(m_d);
        m_cnt++;
        if (m_cnt == N) begin
          m_hold = 1; m_cnt = 0; m_ready = 0; m_valid = 1;
          last_frame = cur_digits;
          cur_digits.delete();
        end else begin
          m_ready = 1;
        end
      end else begin
        m_ready = 1;
      end
    end else if (clr || bcd_ready) begin
      m_hold = 0; m_valid = 0; m_err = 0; m_ready = 1;
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      check("seg_ready", 32'(seg_ready), 32'(m_ready));
      check("bcd_valid", 32'(bcd_valid), 32'(m_valid));
      check("err", 32'(err), 32'(m_err));
      check("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
      check("bcd_out", 32'(bcd_out), 32'(m_bcd));
      if (m_valid) check("frame_order", 32'(bcd_out), 32'(frame_val()));
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_code(logic [6:0] c);
    bit acc;
    seg_valid = 1'b1;
    seg_in    = c;
    for (int i = 0; i < 50; i++) begin
      acc = seg_ready;
      tick();
      if (acc) begin
        seg_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: got no seg_ready in 50 cycles, want accept of %b", c);
    seg_valid = 1'b0;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_seg_ready"}, 32'(seg_ready), 0);
    check({tag, "_bcd_valid"}, 32'(bcd_valid), 0);
    check({tag, "_bcd_out"}, 32'(bcd_out), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_digit_cnt"}, 32'(digit_cnt), 0);
  endtask

  int exp_fr [3] = '{32'h1470, 32'h3692, 32'h5814};

  initial begin
    int k, fr, prev;
    bit acc;
    resetn = 1'b1; seg_valid = 1'b0; seg_in = 7'h7F; clr = 1'b0; bcd_ready = 1'b0;
    #1 resetn = 1'b0;
    #2 chk_en = 1;
    check_zero("reset");
    tick(); tick();
    resetn = 1'b1;
    check("release_ready_low", 32'(seg_ready), 0);
    tick();
    check("release_ready_rise", 32'(seg_ready), 1);

    // 1: 6,2,5,6
    bcd_ready = 1'b1;
    send_code(seg_tab[6]); send_code(seg_tab[2]); send_code(seg_tab[5]); send_code(seg_tab[6]);
    check("t1_valid", 32'(bcd_valid), 1);
    check("t1_bcd", 32'(bcd_out), 32'h6256);
    check("t1_err", 32'(err), 0);
    tick();
    check("t1_valid_drop", 32'(bcd_valid), 0);
    check("t1_ready_back", 32'(seg_ready), 1);

    // 2: blank code in frame
    bcd_ready = 1'b0;
    send_code(seg_tab[6]); send_code(7'b1111111); send_code(seg_tab[5]); send_code(seg_tab[6]);
    check("t2_bcd", 32'(bcd_out), 32'h6F56);
    check("t2_err", 32'(err), 1);
    bcd_ready = 1'b1;
    tick();
    bcd_ready = 1'b0;
    check("t2_err_clear", 32'(err), 0);

    // 3: stalled consumer with source pushing
    send_code(seg_tab[1]); send_code(seg_tab[2]); send_code(seg_tab[3]); send_code(seg_tab[4]);
    seg_valid = 1'b1;
    seg_in    = seg_tab[9];
    repeat (10) begin
      tick();
      check("t3_ready_low", 32'(seg_ready), 0);
      check("t3_bcd_stable", 32'(bcd_out), 32'h1234);
    end
    seg_valid = 1'b0;
    bcd_ready = 1'b1;
    tick();
    bcd_ready = 1'b0;

    // 4: clr mid-frame with simultaneous transfer
    send_code(seg_tab[7]); send_code(seg_tab[8]);
    check("t4_cnt_before", 32'(digit_cnt), 2);
    clr = 1'b1; seg_valid = 1'b1; seg_in = seg_tab[9];
    tick();
    clr = 1'b0; seg_valid = 1'b0;
    check("t4_cnt_after_clr", 32'(digit_cnt), 0);
    check("t4_bcd_after_clr", 32'(bcd_out), 0);
    send_code(seg_tab[0]); send_code(seg_tab[9]); send_code(seg_tab[3]); send_code(seg_tab[5]);
    check("t4_bcd", 32'(bcd_out), 32'h0935);
    check("t4_err", 32'(err), 0);
    bcd_ready = 1'b1;
    tick();

    // 5: streaming, three frames
    k = 0; fr = 0; prev = -1;
    seg_valid = 1'b1;
    seg_in = seg_tab[1];
    for (int cyc = 0; cyc < 25; cyc++) begin
      acc = seg_ready && seg_valid;
      if (bcd_valid) begin
        if (fr < 3) check("t5_frame", 32'(bcd_out), 32'(exp_fr[fr]));
        if (prev >= 0) check("t5_period", 32'(cyc - prev), 5);
        prev = cyc;
        fr++;
      end
      tick();
      if (acc) begin
        k++;
        if (k < 12) seg_in = seg_tab[(k * 3 + 1) % 10];
        else seg_valid = 1'b0;
      end
    end
    check("t5_frame_count", 32'(fr), 3);

    // 6: reset mid-frame
    send_code(seg_tab[2]); send_code(seg_tab[3]);
    resetn = 1'b0;
    #1;
    check_zero("t6_reset");
    tick();
    resetn = 1'b1;
    check("t6_ready_low", 32'(seg_ready), 0);
    tick();
    check("t6_ready_rise", 32'(seg_ready), 1);
    send_code(seg_tab[9]); send_code(seg_tab[8]); send_code(seg_tab[7]); send_code(seg_tab[6]);
    check("t6_bcd", 32'(bcd_out), 32'h9876);
    check("t6_err", 32'(err), 0);
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 299) == 0) resetn = 1'b0;
      clr       = ($urandom_range(0, 29) == 0);
      bcd_ready = 1'($urandom_range(0, 1));
      if (!(seg_valid && !seg_ready)) begin
        seg_valid = ($urandom_range(0, 9) < 7);
        seg_in = ($urandom_range(0, 9) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 9)];
      end
      tick();
    end
    resetn = 1'b1; clr = 1'b0; seg_valid = 1'b0;
    tick();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
